rf_multiport_sb: RTL and testbench
==================================

Name: rf_multiport_sb

Overview:
- Parametrised successor to the CPU integer register file, for the dual-writeback pipeline.
- Provides two write ports, two bypassed read ports, and a raw debug read port.
- Holds a per-register pending-write scoreboard so the hazard unit can stall on registers that are still awaiting writeback.
- Sits between the ID stage (reads, issue marking) and the WB stage (two retire lanes).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers (power of two, at least 2).
- AW, $clog2(NREG), address width (derived; do not override).
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and issue marking.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we0  in  1  write enable, lane 0 (older instruction).
- wa0  in  AW  write address, lane 0.
- wd0  in  XLEN  write data, lane 0.
- we1  in  1  write enable, lane 1 (younger instruction).
- wa1  in  AW  write address, lane 1.
- wd1  in  XLEN  write data, lane 1.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  XLEN  read data, port 1 (combinational, bypassed).
- rd2  out  XLEN  read data, port 2 (combinational, bypassed).
- iss_valid  in  1  issue strobe: mark iss_rd as pending.
- iss_rd  in  AW  destination register of the issuing instruction.
- busy1  out  1  ra1 has a pending write.
- busy2  out  1  ra2 has a pending write.
- dbg_sel  in  AW  debug read select.
- dbg_data  out  XLEN  raw array contents at dbg_sel (no bypass).
- wr_conflict  out  1  registered pulse: both lanes wrote the same address in the previous cycle.

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - All registers clear to 0.
  - Scoreboard clears to all-idle.
  - wr_conflict clears to 0.
  - Writes and issues in the reset cycle are discarded.
  - Combinational outputs then reflect the cleared state: rd1/rd2/dbg_data are 0 unless bypass applies, and busy1/busy2 are 0.
- Write:
  - On the rising edge, rf[wa0]<=wd0 if we0, and rf[wa1]<=wd1 if we1.
  - If we0 & we1 & wa0==wa1, lane 1 wins and wr_conflict=1 on the following cycle only; otherwise wr_conflict=0.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped and never set wr_conflict.
  - iss_rd==0 is ignored.
  - Reads of address 0 return 0 and report busy=0.
- Read (ports 1 and 2 identical, combinational, zero latency). Priority order:
  - address 0 with ZERO_REG → 0;
  - we1 & wa1==ra → wd1;
  - we0 & wa0==ra → wd0;
  - else rf[ra].
  - A value written in cycle N is therefore visible the same cycle via bypass and from the array from cycle N+1.
- Debug port: dbg_data=rf[dbg_sel] straight from the array, no bypass; reg 0 reads 0 when ZERO_REG=1.
- Scoreboard (NREG-bit vector, reg 0 bit tied 0 when ZERO_REG=1). Per rising edge:
  - Clear busy[wa0] if we0, and clear busy[wa1] if we1.
  - Then set busy[iss_rd] if iss_valid.
  - Set beats clear on the same address (a new producer issued while the old one retires).
  - Issue to an already-busy register keeps it busy (no counting).
- busy outputs (combinational):
  - busyN = sb[raN] & ~(retiring this cycle on either lane to raN).
  - Same-cycle issue does not affect busyN; the set takes effect from the next cycle.
- Widths: no arithmetic. Addresses are used unsigned; NREG is a power of two, so all AW-bit addresses are valid.

Test Plan:
1. Reset then read: pulse rst_n low mid-cycle while we0=1, wa0=5, wd0=0xDEADBEEF → after release, dbg_sel=5 gives 0, and busy1=busy2=0 for every ra.
2. Write then read:
   - Cycle N: we0=1, wa0=3, wd0=0x12345678, ra1=3 → rd1=0x12345678 in cycle N (bypass).
   - Cycle N+1: we0=0 → rd1 and dbg_data(3) both 0x12345678.
3. Lane collision: we0=we1=1, wa0=wa1=7, wd0=0x1, wd1=0x2 → rd1(ra1=7)=0x2 the same cycle, rf[7]=0x2 afterwards, and wr_conflict=1 for exactly one cycle.
4. Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF, iss_valid=1, iss_rd=0 → rd1(ra1=0)=0, busy1=0, wr_conflict=0, and dbg_data(0)=0.
5. Scoreboard:
   - iss_valid with iss_rd=9 in cycle N → busy1(ra1=9)=0 in N and 1 in N+1.
   - we0=1, wa0=9 in N+3 → busy1=0 in N+3 (retire bypass) and 0 in N+4.
6. Set beats clear: busy[4]=1, then one cycle with we1=1, wa1=4 and iss_valid=1, iss_rd=4 → busy for reg 4 remains 1 on the next cycle, and rf[4] is updated.

Source files
------------

// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb
// Integer register file for the dual-writeback pipeline, with a per-register
// pending-write scoreboard for the hazard unit.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   we0/wa0/wd0          write lane 0 (older instruction)
//   we1/wa1/wd1          write lane 1 (younger instruction, wins on collision)
//   ra1/rd1, ra2/rd2     combinational read ports with writeback bypass
//   iss_valid/iss_rd     issue strobe marking iss_rd as awaiting writeback
//   busy1/busy2          pending-write status of ra1/ra2
//   dbg_sel/dbg_data     raw array read, no bypass
//   wr_conflict          one-cycle pulse after both lanes wrote the same register
module rf_multiport_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy1,
    output logic            busy2,
    input  logic [AW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_data,
    output logic            wr_conflict
);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic            w0_ok;
    logic            w1_ok;
    logic            iss_ok;

    // Accesses to the hardwired zero register are filtered out up front so the
    // array, scoreboard and conflict detector never see them.
    assign w0_ok  = we0 && !(ZERO_REG && (wa0 == '0));
    assign w1_ok  = we1 && !(ZERO_REG && (wa1 == '0));
    assign iss_ok = iss_valid && !(ZERO_REG && (iss_rd == '0));

    // Bypass priority: zero register, then lane 1 (younger), then lane 0, then array.
    function automatic logic [XLEN-1:0] read_mux(
        input logic [AW-1:0]   ra,
        input logic [XLEN-1:0] arr_val,
        input logic            e0,
        input logic [AW-1:0]   a0,
        input logic [XLEN-1:0] d0,
        input logic            e1,
        input logic [AW-1:0]   a1,
        input logic [XLEN-1:0] d1
    );
        if (ZERO_REG && (ra == '0))
            return '0;
        else if (e1 && (a1 == ra))
            return d1;
        else if (e0 && (a0 == ra))
            return d0;
        else
            return arr_val;
    endfunction

    // A register retiring this cycle is already resolved through the bypass.
    function automatic logic busy_of(
        input logic [AW-1:0]   ra,
        input logic [NREG-1:0] sbv,
        input logic            e0,
        input logic [AW-1:0]   a0,
        input logic            e1,
        input logic [AW-1:0]   a1
    );
        return sbv[ra] && !((e0 && (a0 == ra)) || (e1 && (a1 == ra)));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            if (w0_ok)
                rf[wa0] <= wd0;
            // Lane 1 is assigned last so it wins a same-address collision.
            if (w1_ok)
                rf[wa1] <= wd1;
        end
    end

    // Clears from retirement first, then the issue set, so a new producer
    // issued while the old one retires leaves the register busy.
    always_comb begin
        sb_next = sb;
        if (w0_ok)
            sb_next[wa0] = 1'b0;
        if (w1_ok)
            sb_next[wa1] = 1'b0;
        if (iss_ok)
            sb_next[iss_rd] = 1'b1;
        if (ZERO_REG)
            sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb          <= '0;
            wr_conflict <= 1'b0;
        end else begin
            sb          <= sb_next;
            wr_conflict <= w0_ok && w1_ok && (wa0 == wa1);
        end
    end

    assign rd1      = read_mux(ra1, rf[ra1], we0, wa0, wd0, we1, wa1, wd1);
    assign rd2      = read_mux(ra2, rf[ra2], we0, wa0, wd0, we1, wa1, wd1);
    assign busy1    = busy_of(ra1, sb, we0, wa0, we1, wa1);
    assign busy2    = busy_of(ra2, sb, we0, wa0, we1, wa1);
    assign dbg_data = (ZERO_REG && (dbg_sel == '0)) ? '0 : rf[dbg_sel];

endmodule

// File: tb/tb_rf_multiport_sb.sv
module tb_rf_multiport_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, iss_valid;
    logic [4:0]  wa0, wa1, ra1, ra2, iss_rd, dbg_sel;
    logic [31:0] wd0, wd1;
    logic [31:0] rd1, rd2, dbg_data;
    logic        busy1, busy2, wr_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    rf_multiport_sb dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy1(busy1), .busy2(busy2),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_valid = 0;
    endtask

    initial begin
        rst_n = 0; idle();
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra1 = 0; ra2 = 0; iss_rd = 0; dbg_sel = 0;
        tick(); tick();
        rst_n = 1;

        // Populate reg 5 and mark it busy so the reset has something to clear.
        tick();
        we0 = 1; wa0 = 5; wd0 = 32'hAAAA5555; iss_valid = 1; iss_rd = 5;
        tick();
        idle(); dbg_sel = 5; ra1 = 5; #1;
        check("pre_rst_dbg5", dbg_data, 32'hAAAA5555);
        check("pre_rst_busy5", {31'b0, busy1}, 32'd1);

        // Reset asserted mid-cycle while a write is presented.
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; #1;
        rst_n = 0; #1;
        check("rst_async_dbg5", dbg_data, 32'h0);
        tick();
        idle(); rst_n = 1; #1;
        check("rst_dbg5", dbg_data, 32'h0);
        check("rst_rd1_5", rd1, 32'h0);
        check("rst_conflict", {31'b0, wr_conflict}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = i[4:0]; ra2 = 5'd31 - i[4:0]; #1;
            check("rst_busy1", {31'b0, busy1}, 32'd0);
            check("rst_busy2", {31'b0, busy2}, 32'd0);
        end

        // Write then read, same-cycle bypass and next-cycle array value.
        tick();
        we0 = 1; wa0 = 3; wd0 = 32'h12345678; ra1 = 3; dbg_sel = 3; #1;
        check("wr_bypass_rd1", rd1, 32'h12345678);
        check("wr_dbg_nobypass", dbg_data, 32'h0);
        tick();
        idle(); #1;
        check("wr_array_rd1", rd1, 32'h12345678);
        check("wr_array_dbg", dbg_data, 32'h12345678);

        // Lane collision on reg 7.
        we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h1; wd1 = 32'h2; ra1 = 7; #1;
        check("coll_bypass_rd1", rd1, 32'h2);
        check("coll_conflict_now", {31'b0, wr_conflict}, 32'd0);
        tick();
        idle(); dbg_sel = 7; #1;
        check("coll_dbg7", dbg_data, 32'h2);
        check("coll_conflict_pulse", {31'b0, wr_conflict}, 32'd1);
        tick();
        #1;
        check("coll_conflict_clear", {31'b0, wr_conflict}, 32'd0);

        // Two lanes to distinct registers.
        we0 = 1; wa0 = 10; wd0 = 32'hA; we1 = 1; wa1 = 11; wd1 = 32'hB; ra1 = 10; ra2 = 11; #1;
        check("dual_rd1", rd1, 32'hA);
        check("dual_rd2", rd2, 32'hB);
        tick();
        idle(); dbg_sel = 10; #1;
        check("dual_conflict", {31'b0, wr_conflict}, 32'd0);
        check("dual_dbg10", dbg_data, 32'hA);
        dbg_sel = 11; #1;
        check("dual_dbg11", dbg_data, 32'hB);

        // Zero register: writes, issue and collision all ignored.
        we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; we0 = 1; wa0 = 0; wd0 = 32'h1234;
        iss_valid = 1; iss_rd = 0; ra1 = 0; dbg_sel = 0; #1;
        check("zero_rd1", rd1, 32'h0);
        check("zero_busy1_now", {31'b0, busy1}, 32'd0);
        tick();
        idle(); #1;
        check("zero_dbg0", dbg_data, 32'h0);
        check("zero_rd1_after", rd1, 32'h0);
        check("zero_busy1", {31'b0, busy1}, 32'd0);
        check("zero_conflict", {31'b0, wr_conflict}, 32'd0);

        // Scoreboard issue/retire on reg 9 via lane 0.
        iss_valid = 1; iss_rd = 9; ra1 = 9; #1;
        check("sb_busy_N", {31'b0, busy1}, 32'd0);
        tick();
        idle(); #1;
        check("sb_busy_N1", {31'b0, busy1}, 32'd1);
        tick();
        ra2 = 9; #1;
        check("sb_busy2_N2", {31'b0, busy2}, 32'd1);
        tick();
        we0 = 1; wa0 = 9; wd0 = 32'h99; #1;
        check("sb_retire_busy1", {31'b0, busy1}, 32'd0);
        check("sb_retire_busy2", {31'b0, busy2}, 32'd0);
        tick();
        idle(); #1;
        check("sb_busy_N4", {31'b0, busy1}, 32'd0);

        // Retire through lane 1 on reg 12.
        iss_valid = 1; iss_rd = 12;
        tick();
        idle(); ra2 = 12; #1;
        check("sb12_busy2", {31'b0, busy2}, 32'd1);
        we1 = 1; wa1 = 12; wd1 = 32'hC; #1;
        check("sb12_retire_busy2", {31'b0, busy2}, 32'd0);
        tick();
        idle(); #1;
        check("sb12_after", {31'b0, busy2}, 32'd0);

        // Set beats clear on reg 4.
        iss_valid = 1; iss_rd = 4;
        tick();
        idle(); ra1 = 4; dbg_sel = 4; #1;
        check("sbc_busy_before", {31'b0, busy1}, 32'd1);
        we1 = 1; wa1 = 4; wd1 = 32'h44; iss_valid = 1; iss_rd = 4; #1;
        check("sbc_busy_retiring", {31'b0, busy1}, 32'd0);
        tick();
        idle(); #1;
        check("sbc_busy_after", {31'b0, busy1}, 32'd1);
        check("sbc_dbg4", dbg_data, 32'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
